// File: rtl/sync_fifo_lvl.sv
// Synchronous FIFO with fill-level count, almost-full/empty thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read data.
module sync_fifo_lvl #(
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned ASIZE     = 4,
  parameter int unsigned AFULL_TH  = 14,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             clr_err,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned    Depth    = 1 << ASIZE;
  localparam logic [ASIZE:0] FullCnt  = {1'b1, {ASIZE{1'b0}}};
  localparam logic [ASIZE:0] AfullTh  = AFULL_TH[ASIZE:0];
  localparam logic [ASIZE:0] AemptyTh = AEMPTY_TH[ASIZE:0];

  logic [DSIZE-1:0] r_mem [Depth];
  logic [ASIZE-1:0] r_waddr;
  logic [ASIZE-1:0] r_raddr;
  logic [ASIZE:0]   r_count;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_wr_ok;
  logic             w_rd_ok;

  assign wfull         = (r_count == FullCnt);
  assign rempty        = (r_count == '0);
  assign walmost_full  = (r_count >= AfullTh);
  assign ralmost_empty = (r_count <= AemptyTh);
  assign count         = r_count;
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;

  // Accept decisions ignore the opposite port: a same-cycle read never frees room for a write.
  assign w_wr_ok = winc & ~wfull & ~flush & ~rst;
  assign w_rd_ok = rinc & ~rempty & ~flush & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_waddr     <= '0;
      r_raddr     <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_waddr <= '0;
      r_raddr <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_ok) r_waddr <= r_waddr + 1'b1;
      if (w_rd_ok) r_raddr <= r_raddr + 1'b1;
      if (w_wr_ok && !w_rd_ok) begin
        r_count <= r_count + 1'b1;
      end else if (w_rd_ok && !w_wr_ok) begin
        r_count <= r_count - 1'b1;
      end
      // A new error event wins over a same-cycle clear.
      r_overflow  <= (winc & wfull) | (r_overflow & ~clr_err);
      r_underflow <= (rinc & rempty) | (r_underflow & ~clr_err);
    end
  end

  // Storage has no reset so contents survive rst and flush.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_waddr] <= wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata = rempty ? '0 : r_mem[r_raddr];
`else
  logic [DSIZE-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_rd_ok) begin
      r_rdata <= r_mem[r_raddr];
    end
  end

  assign rdata = r_rdata;
`endif

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Self-checking bench for sync_fifo_lvl: directed vector table, corner sequences, and
// random traffic checked against a queue-based reference model.
module tb_sync_fifo_lvl;

  logic       clk = 1'b0;
  logic       rst, flush, clr_err, winc, rinc;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       wfull, rempty, walmost_full, ralmost_empty, overflow, underflow;
  logic [4:0] count;

  always #5 clk = ~clk;

  sync_fifo_lvl #(
    .DSIZE(8), .ASIZE(4), .AFULL_TH(14), .AEMPTY_TH(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .clr_err      (clr_err),
    .winc         (winc),
    .wdata        (wdata),
    .rinc         (rinc),
    .rdata        (rdata),
    .wfull        (wfull),
    .rempty       (rempty),
    .walmost_full (walmost_full),
    .ralmost_empty(ralmost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue, plus sticky flags and last popped word.
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  logic [7:0] m_rdata = 8'h00;

  typedef struct {
    logic       rst, flush, clr, winc;
    logic [7:0] wdata;
    logic       rinc;
    int         ecount;
    logic [7:0] erdata;
    logic       eovf, eudf;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_rdata();
`ifdef SYNC_FIFO_FWFT_EN
    return (q.size() != 0) ? q[0] : 8'h00;
`else
    return m_rdata;
`endif
  endfunction

  task automatic model(input logic r, input logic f, input logic c, input logic w,
                       input logic [7:0] d, input logic rd);
    bit full, empty;
    full  = (q.size() == 16);
    empty = (q.size() == 0);
    if (r) begin
      q.delete();
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      m_rdata = 8'h00;
    end else if (f) begin
      q.delete();
    end else begin
      m_ovf = (w && full) || (m_ovf && !c);
      m_udf = (rd && empty) || (m_udf && !c);
      if (rd && !empty) m_rdata = q.pop_front();
      if (w && !full) q.push_back(d);
    end
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(q.size()));
    chk("wfull", 32'(wfull), 32'(q.size() == 16));
    chk("rempty", 32'(rempty), 32'(q.size() == 0));
    chk("walmost_full", 32'(walmost_full), 32'(q.size() >= 14));
    chk("ralmost_empty", 32'(ralmost_empty), 32'(q.size() <= 2));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
    chk("rdata", 32'(rdata), 32'(exp_rdata()));
  endtask

  task automatic step(input logic r, input logic f, input logic c, input logic w,
                      input logic [7:0] d, input logic rd);
    rst = r; flush = f; clr_err = c; winc = w; wdata = d; rinc = rd;
    @(posedge clk);
    model(r, f, c, w, d, rd);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; clr_err = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;

    //           rst  fl   clr  winc wdata  rinc cnt rdata  ovf  udf
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 1, 8'h00, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 0, 8'h5A, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 8'h5A, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 0, 8'h5A, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1, 8'h5A, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 2, 8'h5A, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 0, 8'h5A, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 8'h5A, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1, 8'h5A, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 0, 8'h44, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 0, 8'h00, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rst, tbl[i].flush, tbl[i].clr, tbl[i].winc, tbl[i].wdata, tbl[i].rinc);
      chk($sformatf("tbl%0d.count", i), 32'(count), 32'(tbl[i].ecount));
      chk($sformatf("tbl%0d.overflow", i), 32'(overflow), 32'(tbl[i].eovf));
      chk($sformatf("tbl%0d.underflow", i), 32'(underflow), 32'(tbl[i].eudf));
`ifndef SYNC_FIFO_FWFT_EN
      chk($sformatf("tbl%0d.rdata", i), 32'(rdata), 32'(tbl[i].erdata));
`endif
    end

    // Fill to full, then one dropped write.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'(i + 1), 1'b0);
    chk("fill.count", 32'(count), 32'd16);
    chk("fill.wfull", 32'(wfull), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b0);
    chk("ovf.flag", 32'(overflow), 32'd1);
    chk("ovf.count", 32'(count), 32'd16);

    // Drain in order; the dropped 0xAA must never appear.
    for (int i = 0; i < 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk($sformatf("drain%0d", i), 32'(rdata), 32'(i + 1));
`endif
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
      chk($sformatf("drain%0d", i), 32'(rdata), 32'(i + 1));
`endif
    end
    chk("drain.rempty", 32'(rempty), 32'd1);

    // Simultaneous read/write at level 8 across pointer wrap.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'(i + 1), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'(i + 9), 1'b1);
    chk("steady.count", 32'(count), 32'd8);

    // Flush with winc leaves sticky flags; clr_err then clears them.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'hEE, 1'b0);
    chk("flush.count", 32'(count), 32'd0);
    chk("flush.underflow", 32'(underflow), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("clr.underflow", 32'(underflow), 32'd0);

    // Reset at level 9 with a concurrent write.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'(8'h70 + i), 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h99, 1'b0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.rdata", 32'(rdata), 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 99) < 55),
           8'($urandom), ($urandom_range(0, 99) < 50));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
